// File: rtl/sprite_blitter_if.sv
// Pixel-stream, sprite-control and bitmap-write signals for sprite_blitter.
// The master side drives coordinates, shadow inputs and texel writes.
interface sprite_blitter_if #(
    parameter int COLOR_W     = 8,
    parameter int FRAMES_LOG2 = 2,
    parameter int ADDR_W      = 12
);
    logic                   frame_start;
    logic [10:0]            sprite_x;
    logic [10:0]            sprite_y;
    logic [FRAMES_LOG2-1:0] sprite_sel;
    logic                   sprite_en;
    logic                   zoom;
    logic [10:0]            hcount;
    logic [10:0]            vcount;
    logic                   active_in;
    logic [COLOR_W-1:0]     bg_in;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [COLOR_W-1:0]     wr_data;
    logic [COLOR_W-1:0]     pix_out;
    logic                   active_out;
    logic                   hit_out;

    modport master (
        output frame_start, sprite_x, sprite_y, sprite_sel, sprite_en, zoom,
        output hcount, vcount, active_in, bg_in, wr_en, wr_addr, wr_data,
        input  pix_out, active_out, hit_out
    );

    modport slave (
        input  frame_start, sprite_x, sprite_y, sprite_sel, sprite_en, zoom,
        input  hcount, vcount, active_in, bg_in, wr_en, wr_addr, wr_data,
        output pix_out, active_out, hit_out
    );
endinterface

// File: rtl/sprite_blitter.sv
// Sprite overlay stage: multi-frame bitmap in block RAM, per-pixel hit test
// against frame-latched position, colour-key transparency, optional 2x zoom.
module sprite_blitter #(
    parameter int                 COLOR_W     = 8,
    parameter int                 W_LOG2      = 5,
    parameter int                 H_LOG2      = 5,
    parameter int                 FRAMES_LOG2 = 2,
    parameter logic [COLOR_W-1:0] TRANSP_KEY  = COLOR_W'(8'hE3),
    parameter int                 ADDR_W      = FRAMES_LOG2 + H_LOG2 + W_LOG2
) (
    input logic             clk,
    input logic             rst,
    sprite_blitter_if.slave bus
);
    localparam logic [11:0] LIM_W1 = 12'(1 << W_LOG2);
    localparam logic [11:0] LIM_W2 = 12'(2 << W_LOG2);
    localparam logic [11:0] LIM_H1 = 12'(1 << H_LOG2);
    localparam logic [11:0] LIM_H2 = 12'(2 << H_LOG2);

    logic [10:0]            r_x;
    logic [10:0]            r_y;
    logic [FRAMES_LOG2-1:0] r_sel;
    logic                   r_en;
    logic                   r_zoom;

    logic [10:0]            w_x;
    logic [10:0]            w_y;
    logic [FRAMES_LOG2-1:0] w_sel;
    logic                   w_en;
    logic                   w_zoom;
    logic [11:0]            w_dx;
    logic [11:0]            w_dy;
    logic [11:0]            w_lim_w;
    logic [11:0]            w_lim_h;
    logic [W_LOG2-1:0]      w_col;
    logic [H_LOG2-1:0]      w_row;
    logic                   w_hit;
    logic                   w_draw;

    logic [ADDR_W-1:0]      r_addr;
    logic                   r_hit1;
    logic                   r_act1;
    logic [COLOR_W-1:0]     r_bg1;
    logic [COLOR_W-1:0]     r_texel;
    logic                   r_hit2;
    logic                   r_act2;
    logic [COLOR_W-1:0]     r_bg2;
    logic [COLOR_W-1:0]     r_pix_o;
    logic                   r_hit_o;
    logic                   r_act_o;

    logic [COLOR_W-1:0]     r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_sel  <= '0;
            r_en   <= 1'b0;
            r_zoom <= 1'b0;
        end else if (bus.frame_start) begin
            r_x    <= bus.sprite_x;
            r_y    <= bus.sprite_y;
            r_sel  <= bus.sprite_sel;
            r_en   <= bus.sprite_en;
            r_zoom <= bus.sprite_en ? bus.zoom : bus.zoom;
        end
    end

    // A pixel sampled on the same edge as frame_start already sees the new shadows.
    always_comb begin
        w_x    = bus.frame_start ? bus.sprite_x   : r_x;
        w_y    = bus.frame_start ? bus.sprite_y   : r_y;
        w_sel  = bus.frame_start ? bus.sprite_sel : r_sel;
        w_en   = bus.frame_start ? bus.sprite_en  : r_en;
        w_zoom = bus.frame_start ? bus.zoom       : r_zoom;

        w_dx    = {1'b0, bus.hcount} - {1'b0, w_x};
        w_dy    = {1'b0, bus.vcount} - {1'b0, w_y};
        w_lim_w = w_zoom ? LIM_W2 : LIM_W1;
        w_lim_h = w_zoom ? LIM_H2 : LIM_H1;
        w_hit   = w_en && (bus.hcount >= w_x) && (bus.vcount >= w_y)
                  && (w_dx < w_lim_w) && (w_dy < w_lim_h);
        w_col   = w_zoom ? w_dx[W_LOG2:1] : w_dx[W_LOG2-1:0];
        w_row   = w_zoom ? w_dy[H_LOG2:1] : w_dy[H_LOG2-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_hit1 <= 1'b0;
            r_act1 <= 1'b0;
            r_bg1  <= '0;
            r_hit2 <= 1'b0;
            r_act2 <= 1'b0;
            r_bg2  <= '0;
        end else begin
            r_addr <= {w_sel, w_row, w_col};
            r_hit1 <= w_hit;
            r_act1 <= bus.active_in;
            r_bg1  <= bus.bg_in;
            r_hit2 <= r_hit1;
            r_act2 <= r_act1;
            r_bg2  <= r_bg1;
        end
    end

    // Read-first RAM: a same-edge write to r_addr is seen only by the next read.
    always_ff @(posedge clk) begin
        r_texel <= r_mem[r_addr];
        if (bus.wr_en) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign w_draw = r_act2 && r_hit2 && (r_texel != TRANSP_KEY);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_o <= '0;
            r_hit_o <= 1'b0;
            r_act_o <= 1'b0;
        end else begin
            r_act_o <= r_act2;
            r_hit_o <= w_draw;
            if (!r_act2) begin
                r_pix_o <= '0;
            end else if (w_draw) begin
                r_pix_o <= r_texel;
            end else begin
                r_pix_o <= r_bg2;
            end
        end
    end

    assign bus.pix_out    = r_pix_o;
    assign bus.hit_out    = r_hit_o;
    assign bus.active_out = r_act_o;
endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: directed pixels push expected results,
// a negedge monitor pops and compares whenever active_out is presented.
module tb_sprite_blitter;
    typedef struct {
        string      name;
        logic [7:0] pix;
        logic       hit;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];
    exp_t mon_e;

    sprite_blitter_if #(.COLOR_W(8), .FRAMES_LOG2(2), .ADDR_W(12)) bus ();

    sprite_blitter #(
        .COLOR_W(8), .W_LOG2(5), .H_LOG2(5), .FRAMES_LOG2(2), .TRANSP_KEY(8'hE3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Bitmap pattern: top bit always 0, so never equal to the colour key.
    function automatic logic [7:0] pat(int f, int r, int c);
        return {1'b0, 2'(f), 2'(r), 3'(c)};
    endfunction

    task automatic pix(string nm, int h, int v, logic [7:0] bg, logic [7:0] ep, logic eh);
        bus.hcount    = 11'(h);
        bus.vcount    = 11'(v);
        bus.bg_in     = bg;
        bus.active_in = 1'b1;
        q.push_back('{nm, ep, eh});
        @(negedge clk);
        bus.active_in = 1'b0;
    endtask

    task automatic blank(int h, int v);
        bus.hcount    = 11'(h);
        bus.vcount    = 11'(v);
        bus.active_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_sprite(int x, int y, int sel, logic en, logic zm);
        bus.sprite_x    = 11'(x);
        bus.sprite_y    = 11'(y);
        bus.sprite_sel  = 2'(sel);
        bus.sprite_en   = en;
        bus.zoom        = zm;
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.active_out) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: pix_out=%h hit_out=%b, required no active output",
                             bus.pix_out, bus.hit_out);
                end else begin
                    mon_e = q.pop_front();
                    if (bus.pix_out !== mon_e.pix || bus.hit_out !== mon_e.hit) begin
                        errors++;
                        $display("FAIL %s: pix_out=%h hit_out=%b, required pix_out=%h hit_out=%b",
                                 mon_e.name, bus.pix_out, bus.hit_out, mon_e.pix, mon_e.hit);
                    end
                end
            end else begin
                checks++;
                if (bus.pix_out !== 8'h00 || bus.hit_out !== 1'b0) begin
                    errors++;
                    $display("FAIL inactive_zero: pix_out=%h hit_out=%b, required 00/0",
                             bus.pix_out, bus.hit_out);
                end
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.frame_start = 1'b0;
        bus.sprite_x    = '0;
        bus.sprite_y    = '0;
        bus.sprite_sel  = '0;
        bus.sprite_en   = 1'b0;
        bus.zoom        = 1'b0;
        bus.hcount      = '0;
        bus.vcount      = '0;
        bus.active_in   = 1'b0;
        bus.bg_in       = '0;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int a = 0; a < 4096; a++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 12'(a);
            bus.wr_data = (a == 0)   ? 8'h1C :
                          (a == 165) ? 8'hE3 : pat(a >> 10, (a >> 5) & 31, a & 31);
            @(negedge clk);
        end
        bus.wr_en = 1'b0;

        // Reset mid-stream with hitting pixels in flight
        set_sprite(0, 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.hcount    = 11'(i);
            bus.vcount    = '0;
            bus.bg_in     = 8'h03;
            bus.active_in = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.pix_out !== 8'h00) begin
            errors++;
            $display("FAIL rst_pix: pix_out=%h, required 00", bus.pix_out);
        end
        checks++;
        if (bus.active_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_active: active_out=%b, required 0", bus.active_out);
        end
        checks++;
        if (bus.hit_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_hit: hit_out=%b, required 0", bus.hit_out);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.active_in = 1'b0;
        mon_en = 1'b1;
        pix("rst_hidden", 0, 0, 8'h03, 8'h03, 1'b0);
        blank(0, 0);

        // 1x sprite at (100,50), edges of the 32x32 box
        set_sprite(100, 50, 0, 1'b1, 1'b0);
        pix("hit_origin",  100, 50, 8'h03, 8'h1C, 1'b1);
        pix("left_of",      99, 50, 8'h03, 8'h03, 1'b0);
        pix("right_of",    132, 50, 8'h03, 8'h03, 1'b0);
        pix("last_col",    131, 50, 8'h03, 8'h07, 1'b1);
        pix("last_row",    100, 81, 8'h03, 8'h18, 1'b1);
        pix("below",       100, 82, 8'h03, 8'h03, 1'b0);
        pix("transparent", 105, 55, 8'h55, 8'h55, 1'b0);
        blank(105, 55);

        // 2x zoom at origin
        set_sprite(0, 0, 0, 1'b1, 1'b1);
        pix("zoom_00",  0,  0, 8'h03, 8'h1C, 1'b1);
        pix("zoom_10",  1,  0, 8'h03, 8'h1C, 1'b1);
        pix("zoom_01",  0,  1, 8'h03, 8'h1C, 1'b1);
        pix("zoom_11",  1,  1, 8'h03, 8'h1C, 1'b1);
        pix("zoom_20",  2,  0, 8'h03, 8'h01, 1'b1);
        pix("zoom_far", 63, 63, 8'h03, 8'h1F, 1'b1);
        pix("zoom_out", 64,  0, 8'h03, 8'h03, 1'b0);

        // Shadowing: position only changes on frame_start
        set_sprite(100, 50, 0, 1'b1, 1'b0);
        bus.sprite_x = 11'd200;
        pix("no_tear_old", 100, 50, 8'h03, 8'h1C, 1'b1);
        pix("no_tear_new", 200, 50, 8'h03, 8'h03, 1'b0);
        set_sprite(200, 50, 0, 1'b1, 1'b0);
        pix("moved_new",   200, 50, 8'h03, 8'h1C, 1'b1);
        pix("moved_old",   100, 50, 8'h03, 8'h03, 1'b0);
        set_sprite(1010, 50, 0, 1'b1, 1'b0);
        pix("clip_before", 1009, 50, 8'h03, 8'h03, 1'b0);
        pix("clip_start",  1010, 50, 8'h03, 8'h1C, 1'b1);
        pix("clip_edge",   1023, 50, 8'h03, 8'h05, 1'b1);
        blank(1024, 50);
        pix("fs_before",   1010, 50, 8'h03, 8'h1C, 1'b1);
        bus.sprite_x    = 11'd300;
        bus.frame_start = 1'b1;
        pix("fs_same_edge", 300, 50, 8'h03, 8'h1C, 1'b1);
        bus.frame_start = 1'b0;
        pix("fs_after_old", 1010, 50, 8'h03, 8'h03, 1'b0);

        // Read-first collision, then frame select
        set_sprite(0, 0, 0, 1'b1, 1'b0);
        pix("rf_old", 0, 0, 8'h03, 8'h1C, 1'b1);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 12'd0;
        bus.wr_data = 8'h44;
        pix("rf_new", 0, 0, 8'h03, 8'h44, 1'b1);
        bus.wr_en = 1'b0;
        pix("rf_again", 0, 0, 8'h03, 8'h44, 1'b1);
        set_sprite(0, 0, 3, 1'b1, 1'b0);
        pix("sel3_00",   0,  0, 8'h03, 8'h60, 1'b1);
        pix("sel3_3131", 31, 31, 8'h03, 8'h7F, 1'b1);
        pix("sel3_out",  32,  0, 8'h03, 8'h03, 1'b0);
        set_sprite(0, 0, 3, 1'b0, 1'b0);
        pix("disabled",  0,  0, 8'h03, 8'h03, 1'b0);

        repeat (6) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected outputs never seen, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
